// File: rtl/ascii_hex_parser.sv
// Streaming ASCII hex token parser: accumulates hex digits into a word and emits it
// when a delimiter arrives, with a valid/ready handshake on both sides.
module ascii_hex_parser #(
  parameter int unsigned SIZE_DATA_IN = 8,
  parameter int unsigned NUM_DIGITS   = 8,
  localparam int unsigned W = 4 * NUM_DIGITS,
  localparam int unsigned C = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic [SIZE_DATA_IN-1:0] i_data,
  output logic                    o_ready,
  output logic                    o_valid,
  output logic [W-1:0]            o_data,
  output logic [C-1:0]            o_num_digits,
  output logic                    o_err,
  input  logic                    i_ready
);

  localparam logic [SIZE_DATA_IN-1:0] Ch0     = SIZE_DATA_IN'(8'h30);
  localparam logic [SIZE_DATA_IN-1:0] Ch9     = SIZE_DATA_IN'(8'h39);
  localparam logic [SIZE_DATA_IN-1:0] ChUpA   = SIZE_DATA_IN'(8'h41);
  localparam logic [SIZE_DATA_IN-1:0] ChUpF   = SIZE_DATA_IN'(8'h46);
  localparam logic [SIZE_DATA_IN-1:0] ChLoA   = SIZE_DATA_IN'(8'h61);
  localparam logic [SIZE_DATA_IN-1:0] ChLoF   = SIZE_DATA_IN'(8'h66);
  localparam logic [SIZE_DATA_IN-1:0] ChSpace = SIZE_DATA_IN'(8'h20);
  localparam logic [SIZE_DATA_IN-1:0] ChCr    = SIZE_DATA_IN'(8'h0D);
  localparam logic [SIZE_DATA_IN-1:0] ChLf    = SIZE_DATA_IN'(8'h0A);
  localparam logic [SIZE_DATA_IN-1:0] ChComma = SIZE_DATA_IN'(8'h2C);
  localparam logic [C-1:0]            CntMax  = C'(NUM_DIGITS);

  typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [C-1:0]     cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [W-1:0]     data_q, data_d;
  logic [C-1:0]     num_q, num_d;
  logic             oerr_q, oerr_d;

  logic             accept;
  logic             is_digit, is_upper, is_lower, is_hex, is_delim;
  logic [3:0]       nibble;

  // Character classification
  always_comb begin
    is_digit = (i_data >= Ch0)   && (i_data <= Ch9);
    is_upper = (i_data >= ChUpA) && (i_data <= ChUpF);
    is_lower = (i_data >= ChLoA) && (i_data <= ChLoF);
    is_hex   = is_digit || is_upper || is_lower;
    is_delim = (i_data == ChSpace) || (i_data == ChCr) || (i_data == ChLf) ||
               (i_data == ChComma);
    // Letters share low nibble 1..6 in both cases, so +9 maps them to A..F.
    nibble   = is_digit ? i_data[3:0] : (i_data[3:0] + 4'd9);
  end

  assign accept = i_valid && ready_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ready_d = ready_q;
    valid_d = valid_q;
    data_d  = data_q;
    num_d   = num_q;
    oerr_d  = oerr_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_hex) begin
            acc_d   = W'(nibble);
            cnt_d   = C'(1);
            state_d = StAccum;
          end else if (!is_delim) begin
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        if (accept) begin
          if (is_hex) begin
            if (cnt_q != CntMax) begin
              acc_d = (acc_q << 4) | W'(nibble);
              cnt_d = cnt_q + C'(1);
            end else begin
              err_d = 1'b1;
            end
          end else if (is_delim) begin
            state_d = StEmit;
            data_d  = acc_q;
            num_d   = cnt_q;
            oerr_d  = err_q;
            valid_d = 1'b1;
            ready_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StEmit: begin
        if (i_ready) begin
          state_d = StIdle;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        acc_d   = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      num_q   <= '0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      num_q   <= num_d;
      oerr_q  <= oerr_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_valid      = valid_q;
  assign o_data       = data_q;
  assign o_num_digits = num_q;
  assign o_err        = oerr_q;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Scoreboard bench for ascii_hex_parser: directed token streams push expected words,
// a monitor pops and compares on each output handshake.
module tb_ascii_hex_parser;
  localparam int unsigned ND = 8;
  localparam int unsigned W  = 4 * ND;
  localparam int unsigned C  = $clog2(ND + 1);

  logic         clk = 1'b0;
  logic         i_rst, i_valid, i_ready;
  logic [7:0]   i_data;
  logic         o_ready, o_valid, o_err;
  logic [W-1:0] o_data;
  logic [C-1:0] o_num_digits;

  typedef struct packed {
    logic [W-1:0] data;
    logic [C-1:0] num;
    logic         err;
  } word_t;

  word_t exp_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  always #5 clk = ~clk;

  ascii_hex_parser #(.SIZE_DATA_IN(8), .NUM_DIGITS(ND)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_num_digits(o_num_digits),
    .o_err       (o_err),
    .i_ready     (i_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: one pop per completed output handshake
  always @(negedge clk) begin
    word_t got, want;
    if (!i_rst && o_valid && i_ready) begin
      got.data = o_data;
      got.num  = o_num_digits;
      got.err  = o_err;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_word: got data=%0h num=%0d err=%0b, expected no word",
                 got.data, got.num, got.err);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_miss++;
          $display("FAIL word: got data=%0h num=%0d err=%0b, expected data=%0h num=%0d err=%0b",
                   got.data, got.num, got.err, want.data, want.num, want.err);
        end
      end
    end
  end

  task automatic send_char(input logic [7:0] c);
    int t;
    i_valid = 1'b1;
    i_data  = c;
    t       = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!o_ready && t < 50);
    if (!o_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: o_ready=0 after 50 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic send_token(input string s, input logic [W-1:0] d, input int n,
                            input logic e);
    word_t w;
    w.data = d;
    w.num  = C'(n);
    w.err  = e;
    exp_q.push_back(w);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    @(negedge clk);
    check("latency_o_valid", o_valid, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_o_ready", o_ready, 1);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_num_digits", o_num_digits, 0);
    check("rst_o_err", o_err, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    string delims;
    int    t;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    check_reset_state();

    send_token("1A2b\015", 32'h00001A2B, 4, 1'b0);

    delims = " ,\n\015";
    for (int i = 0; i < delims.len(); i++) begin
      send_char(delims[i]);
      @(negedge clk);
      check("delim_only_o_valid", o_valid, 0);
      check("delim_only_o_ready", o_ready, 1);
      @(posedge clk);
      #1;
    end

    send_token("123456789 ", 32'h12345678, 8, 1'b1);
    send_token("12G4,", 32'h00000124, 3, 1'b1);
    send_token("G ", 32'h0, 0, 1'b1);
    send_token("9aF0C3e1\n", 32'h9AF0C3E1, 8, 1'b0);
    send_token("@`g/: ", 32'h0, 0, 1'b1);
    send_token("ff,", 32'h000000FF, 2, 1'b0);
    send_token("  0\n", 32'h0, 1, 1'b0);

    // Backpressure: word held while downstream stalls, input blocked
    i_ready = 1'b0;
    send_token("FF ", 32'h000000FF, 2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_o_valid", o_valid, 1);
      check("stall_o_ready", o_ready, 0);
      check("stall_o_data", o_data, 32'hFF);
      check("stall_o_num_digits", o_num_digits, 2);
      check("stall_o_err", o_err, 0);
      @(posedge clk);
      #1;
    end
    i_valid = 1'b1;
    i_data  = "7";
    @(negedge clk);
    check("stall_blocks_input", o_ready, 0);
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    send_token("7 ", 32'h7, 1, 1'b0);

    // Reset mid-token discards it; char in reset cycle ignored
    send_char("A");
    send_char("B");
    i_rst   = 1'b1;
    i_valid = 1'b1;
    i_data  = "D";
    @(posedge clk);
    #1;
    i_rst   = 1'b0;
    i_valid = 1'b0;
    check_reset_state();
    send_token("C ", 32'h0000000C, 1, 1'b0);

    // Reset during a pending word discards it
    i_ready = 1'b0;
    send_char("5");
    send_char(" ");
    @(negedge clk);
    check("pending_o_valid", o_valid, 1);
    @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    i_rst   = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    check("rst_drops_pending", o_valid, 0);
    @(posedge clk);
    #1;
    send_token("e\n", 32'hE, 1, 1'b0);

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (20) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
